// File: rtl/imem_loader.sv
// Boot-time loader: receives a length-prefixed little-endian byte stream, writes the
// assembled words to instruction memory from address 0, and releases the CPU on a good checksum.
module imem_loader #(
    parameter int INSN_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [INSN_WIDTH-1:0] im_wdata,
    output logic                  cpu_run,
    output logic                  error
);

    localparam int BYTES  = INSN_WIDTH / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [31:0] CAPACITY = 32'(1) << ADDR_WIDTH;

    localparam logic [BIDX_W-1:0]   BIDX_ONE  = 1;
    localparam logic [BIDX_W-1:0]   BIDX_LAST = BIDX_W'(BYTES - 1);
    localparam logic [ADDR_WIDTH:0] WIDX_ONE  = 1;

    localparam logic [2:0] S_LEN_LO = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CSUM   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    logic [2:0]            state;
    logic [7:0]            len_lo;
    logic [15:0]           len;
    logic [ADDR_WIDTH:0]   word_idx;
    logic [BIDX_W-1:0]     byte_idx;
    logic [INSN_WIDTH-1:0] asm_word;
    logic [INSN_WIDTH-1:0] next_word;
    logic [7:0]            sum;
    logic [15:0]           new_len;
    logic                  accept;
    logic                  last_byte;
    logic                  last_word;

    assign in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA)   || (state == S_CSUM);
    assign cpu_run  = (state == S_DONE);
    assign error    = (state == S_ERROR);

    assign accept    = in_valid && in_ready;
    assign new_len   = {in_data, len_lo};
    assign last_byte = (byte_idx == BIDX_LAST);
    // word_idx is one bit wider than im_addr so a full memory (N = 2^ADDR_WIDTH) ends cleanly
    assign last_word = ((32'(word_idx) + 32'd1) == 32'(len));

    always_comb begin
        next_word = asm_word;
        for (int lane = 0; lane < BYTES; lane++) begin
            if (byte_idx == BIDX_W'(lane)) begin
                next_word[lane*8 +: 8] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_LEN_LO;
            len_lo   <= 8'd0;
            len      <= 16'd0;
            word_idx <= '0;
            byte_idx <= '0;
            asm_word <= '0;
            sum      <= 8'd0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
        end else begin
            im_we <= 1'b0;
            if (accept && (state != S_CSUM)) begin
                sum <= sum + in_data;
            end
            case (state)
                S_LEN_LO: begin
                    if (accept) begin
                        len_lo <= in_data;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len <= new_len;
                        if (32'(new_len) > CAPACITY) begin
                            state <= S_ERROR;
                        end else if (new_len == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        if (last_byte) begin
                            im_we    <= 1'b1;
                            im_addr  <= word_idx[ADDR_WIDTH-1:0];
                            im_wdata <= next_word;
                            word_idx <= word_idx + WIDX_ONE;
                            byte_idx <= '0;
                            if (last_word) begin
                                state <= S_CSUM;
                            end
                        end else begin
                            asm_word <= next_word;
                            byte_idx <= byte_idx + BIDX_ONE;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        state <= (in_data == sum) ? S_DONE : S_ERROR;
                    end
                end
                S_DONE, S_ERROR: begin
                end
                // Unreachable encodings park in ERROR so the CPU is never released by accident
                default: begin
                    state <= S_ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: expected writes and outcomes come from a
// byte-stream reference model; a monitor compares every im_we pulse against the queue.
module tb_imem_loader;

    localparam int IW    = 16;
    localparam int AW    = 4;
    localparam int BYTES = IW / 8;
    localparam int CAP   = 1 << AW;

    typedef logic [7:0] bq_t [$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [IW-1:0] im_wdata;
    logic          cpu_run;
    logic          error;

    always #5 clk = ~clk;

    imem_loader #(.INSN_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_run  (cpu_run),
        .error    (error)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    wr_t           sb[$];
    wr_t           mon_e;
    logic [IW-1:0] dut_mem   [CAP];
    logic [IW-1:0] model_mem [CAP];
    bit            prev_we = 1'b0;
    bit            exp_run;
    bit            exp_err;
    bit            exp_ovf;
    int            exp_n;
    int            term_idx;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: parse the stream by its format rules and predict writes and outcome
    function automatic void model(input bq_t s);
        logic [7:0]    cs;
        logic [IW-1:0] d;
        wr_t           w;
        exp_n = int'(s[0]) + (int'(s[1]) * 256);
        if (exp_n > CAP) begin
            exp_ovf  = 1'b1;
            exp_err  = 1'b1;
            exp_run  = 1'b0;
            term_idx = 1;
            return;
        end
        exp_ovf  = 1'b0;
        term_idx = 2 + BYTES * exp_n;
        for (int k = 0; k < exp_n; k++) begin
            for (int b = 0; b < BYTES; b++) begin
                d[8*b +: 8] = s[2 + BYTES*k + b];
            end
            w.addr = AW'(k);
            w.data = d;
            sb.push_back(w);
            model_mem[k] = d;
        end
        cs = 8'd0;
        for (int j = 0; j < term_idx; j++) begin
            cs = cs + s[j];
        end
        exp_run = (s[term_idx] == cs);
        exp_err = !exp_run;
    endfunction

    function automatic bq_t build(input int n, input bit pattern, input bit corrupt);
        bq_t           s;
        logic [7:0]    cs;
        logic [IW-1:0] w;
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        if (n > CAP) begin
            s.push_back(8'($urandom));
            s.push_back(8'($urandom));
            return s;
        end
        for (int k = 0; k < n; k++) begin
            w = pattern ? IW'(32'h0100 + k) : IW'($urandom);
            for (int b = 0; b < BYTES; b++) begin
                s.push_back(w[8*b +: 8]);
            end
        end
        cs = 8'd0;
        foreach (s[j]) cs = cs + s[j];
        if (corrupt) begin
            cs = cs + 8'(1 + $urandom_range(254));
        end
        s.push_back(cs);
        return s;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0 && im_we === 1'b1) begin
            check_output("we_width", prev_we, 0);
            check_output("write_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check_output("wr_addr", im_addr, mon_e.addr);
                check_output("wr_data", im_wdata, mon_e.data);
            end
            dut_mem[im_addr] = im_wdata;
        end
        prev_we = (im_we === 1'b1);
    end

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        check_output("rst_in_ready", in_ready, 1);
        check_output("rst_im_we", im_we, 0);
        check_output("rst_im_addr", im_addr, 0);
        check_output("rst_im_wdata", im_wdata, 0);
        check_output("rst_cpu_run", cpu_run, 0);
        check_output("rst_error", error, 0);
    endtask

    task automatic apply_stimulus(input bq_t s, input int idle_pct);
        int i       = 0;
        int guard   = 0;
        bit acc;
        bit reached = 1'b0;
        bit wend;
        model(s);
        @(negedge clk);
        while (i < s.size() && guard < 5000) begin
            guard++;
            if (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end else begin
                in_valid = 1'b1;
                in_data  = s[i];
                acc      = in_ready;
                @(negedge clk);
                in_valid = 1'b0;
                if (!acc) break;
                wend = !exp_ovf && i >= 2 && i < term_idx && ((i - 2) % BYTES) == BYTES - 1;
                check_output("we_timing", im_we, wend);
                if (i < term_idx) begin
                    check_output("early_run", cpu_run, 0);
                    check_output("early_error", error, 0);
                end else if (i == term_idx) begin
                    reached = 1'b1;
                    check_output("cpu_run", cpu_run, exp_run);
                    check_output("error", error, exp_err);
                    check_output("in_ready_low", in_ready, 0);
                end
                i++;
            end
        end
        check_output("terminal_reached", reached, 1);
        repeat (3) @(negedge clk);
        check_output("pending_writes", sb.size(), 0);
        sb.delete();
        if (!exp_ovf) begin
            for (int k = 0; k < exp_n; k++) begin
                check_output("mem_content", dut_mem[k], model_mem[k]);
            end
        end
        check_output("run_hold", cpu_run, exp_run);
        check_output("error_hold", error, exp_err);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bq_t s;
        int  n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;

        do_reset();
        s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16};
        apply_stimulus(s, 0);

        do_reset();
        s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h17};
        apply_stimulus(s, 0);

        do_reset();
        s = '{8'h00, 8'h00, 8'h00};
        apply_stimulus(s, 0);

        do_reset();
        s = '{8'h01, 8'h01, 8'h34, 8'h12, 8'h00};
        apply_stimulus(s, 0);

        do_reset();
        s = build(CAP + 1, 1'b0, 1'b0);
        apply_stimulus(s, 0);

        do_reset();
        s = build(CAP, 1'b1, 1'b0);
        apply_stimulus(s, 0);

        do_reset();
        s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16};
        apply_stimulus(s, 60);

        // Abort a load after three bytes, then the full stream must load from address 0 again
        do_reset();
        s = '{8'hA5, 8'h5A, 8'h3C};
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_data  = s[j];
            @(negedge clk);
        end
        in_valid = 1'b0;
        do_reset();
        s = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16};
        apply_stimulus(s, 0);

        for (int t = 0; t < 10; t++) begin
            do_reset();
            n = $urandom_range(0, CAP + 3);
            s = build(n, 1'b0, ($urandom_range(3) == 0));
            apply_stimulus(s, ($urandom_range(1) == 1) ? 50 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
